// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers, baseline types and parameter sanity checks for the sync FIFO.
package sync_fifo_pkg;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_AW    = addr_w(DEF_DEPTH);

    // Types for the baseline 16x16 configuration; pointers carry one wrap bit.
    typedef logic [DEF_AW:0]      ptr_t;
    typedef logic [DEF_AW:0]      cnt_t;
    typedef logic [DEF_WIDTH-1:0] word_t;

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit thresh_ok(input int depth, input int af, input int ae);
        return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer side of the sync FIFO: write/read handshakes, status and interrupt.
interface sync_fifo_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    import sync_fifo_pkg::*;

    localparam int AW = addr_w(DEPTH);

    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;
    logic             irq_en;
    logic             irq_clr;
    logic             interrupt;

    modport master (
        output wr_en, data_in, rd_en, irq_en, irq_clr,
        input  data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow, interrupt
    );

    modport slave (
        input  wr_en, data_in, rd_en, irq_en, irq_clr,
        output data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow, interrupt
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH simple dual-port storage; read port is registered (FWFT=0) or
// combinational on the head entry (FWFT=1).
module sync_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int FWFT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    input  logic             head_vld,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q, rdata_d;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    // In FWFT mode an empty FIFO presents zero rather than a stale entry.
    always_comb begin
        rdata = rdata_q;
        if (FWFT != 0) rdata = head_vld ? mem[raddr] : '0;
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Parametrised single-clock FIFO controller: pointers, fill count, status flags,
// sticky error flags and a maskable level interrupt around sync_fifo_mem.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 0
) (
    input  logic           clk,
    input  logic           rst,
    sync_fifo_ctrl_if.slave bus
);

    localparam int AW = addr_w(DEPTH);
    localparam logic [AW:0] AF_C = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_C = (AW+1)'(AE_THRESH);

    if (!depth_ok(DEPTH) || WIDTH < 1) begin : g_bad_geom
        $error("sync_fifo_ctrl: DEPTH must be a power of 2 >= 2 and WIDTH >= 1");
    end
    if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
        $error("sync_fifo_ctrl: AF_THRESH must be 1..DEPTH, AE_THRESH 0..DEPTH-1");
    end

    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
    logic        full_q, full_d, empty_q, empty_d;
    logic        af_q, af_d, ae_q, ae_d;
    logic        ovf_q, ovf_d, unf_q, unf_d;
    logic        irq_q, irq_d, dv_q, dv_d;
    logic        wr_acc, rd_acc;

    always_comb begin
        wr_acc   = bus.wr_en & ~full_q;
        rd_acc   = bus.rd_en & ~empty_q;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_acc};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_acc};
        cnt_d    = cnt_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
        // Flags come from next-state values so they line up with the pointer update.
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        af_d     = (cnt_d >= AF_C);
        ae_d     = (cnt_d <= AE_C);
        // A new error in the same cycle as irq_clr keeps the flag set.
        ovf_d    = ovf_q & ~bus.irq_clr;
        unf_d    = unf_q & ~bus.irq_clr;
        if (bus.wr_en & full_q)  ovf_d = 1'b1;
        if (bus.rd_en & empty_q) unf_d = 1'b1;
        irq_d    = (ovf_q | unf_q | af_q) & bus.irq_en;
        dv_d     = rd_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            irq_q    <= 1'b0;
            dv_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            irq_q    <= irq_d;
            dv_q     <= dv_d;
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW),
        .FWFT  (FWFT)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .we       (wr_acc),
        .waddr    (wr_ptr_q[AW-1:0]),
        .wdata    (bus.data_in),
        .re       (rd_acc),
        .raddr    (rd_ptr_q[AW-1:0]),
        .head_vld (~empty_q),
        .rdata    (bus.data_out)
    );

    assign bus.data_valid   = (FWFT != 0) ? ~empty_q : dv_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = cnt_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
    assign bus.interrupt    = irq_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed scoreboard bench for sync_fifo_ctrl: registered-read instance plus an FWFT instance.
module tb_sync_fifo_ctrl;
    import sync_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sync_fifo_ctrl_if #(.WIDTH(16), .DEPTH(16)) bus0 ();
    sync_fifo_ctrl_if #(.WIDTH(16), .DEPTH(16)) bus1 ();

    sync_fifo_ctrl #(.WIDTH(16), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(0))
        u_dut (.clk(clk), .rst(rst), .bus(bus0));
    sync_fifo_ctrl #(.WIDTH(16), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(1))
        u_fwft (.clk(clk), .rst(rst), .bus(bus1));

    int    total = 0;
    int    bad   = 0;
    word_t mq[$];
    word_t last_out;
    bit    ovf_m, unf_m, irq_en_v, irq_clr_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status();
        chk("count",        32'(bus0.count), 32'(cnt_t'(mq.size())));
        chk("full",         32'(bus0.full), 32'(mq.size() == 16));
        chk("empty",        32'(bus0.empty), 32'(mq.size() == 0));
        chk("almost_full",  32'(bus0.almost_full), 32'(mq.size() >= 12));
        chk("almost_empty", 32'(bus0.almost_empty), 32'(mq.size() <= 4));
        chk("overflow",     32'(bus0.overflow), 32'(ovf_m));
        chk("underflow",    32'(bus0.underflow), 32'(unf_m));
    endtask

    // One clock of stimulus on the registered-read instance; expectations come from the queue model.
    task automatic cyc(input bit w, input bit r, input word_t d);
        bit    old_src, exp_irq, wacc, racc;
        word_t exp_d;
        old_src = ovf_m | unf_m | (mq.size() >= 12);
        exp_irq = old_src & irq_en_v;
        wacc    = w && (mq.size() < 16);
        racc    = r && (mq.size() > 0);
        if (irq_clr_v) begin ovf_m = 1'b0; unf_m = 1'b0; end
        if (w && !wacc) ovf_m = 1'b1;
        if (r && !racc) unf_m = 1'b1;
        exp_d = last_out;
        if (racc) exp_d = mq.pop_front();
        if (wacc) mq.push_back(d);
        last_out = exp_d;
        bus0.wr_en   = w;
        bus0.rd_en   = r;
        bus0.data_in = d;
        bus0.irq_en  = irq_en_v;
        bus0.irq_clr = irq_clr_v;
        tick();
        chk("data_valid", 32'(bus0.data_valid), 32'(racc));
        chk("data_out",   32'(bus0.data_out), 32'(exp_d));
        chk("interrupt",  32'(bus0.interrupt), 32'(exp_irq));
        check_status();
    endtask

    task automatic model_reset();
        mq.delete();
        last_out = '0;
        ovf_m    = 1'b0;
        unf_m    = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check_status();
        chk("rst_data_out",   32'(bus0.data_out), 32'h0);
        chk("rst_data_valid", 32'(bus0.data_valid), 32'h0);
        chk("rst_interrupt",  32'(bus0.interrupt), 32'h0);
        chk("rst_fwft_empty", 32'(bus1.empty), 32'h1);
        chk("rst_fwft_count", 32'(bus1.count), 32'h0);
    endtask

    initial begin
        bus0.wr_en = 0; bus0.rd_en = 0; bus0.data_in = '0; bus0.irq_en = 0; bus0.irq_clr = 0;
        bus1.wr_en = 0; bus1.rd_en = 0; bus1.data_in = '0; bus1.irq_en = 0; bus1.irq_clr = 0;
        irq_en_v = 0; irq_clr_v = 0;
        model_reset();

        // Reset state
        rst = 1'b1;
        tick(); tick();
        check_reset_outputs();
        #2 rst = 1'b0;

        // Fill 16, then drain in order
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, word_t'(i));
        for (int i = 0; i < 16; i++)  cyc(1'b0, 1'b1, '0);

        // Overflow, interrupt, irq_clr, read+write on full
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, word_t'(16'h0100 + i));
        cyc(1'b1, 1'b0, 16'hBEEF);
        irq_en_v = 1'b1;
        cyc(1'b0, 1'b0, '0);
        irq_clr_v = 1'b1;
        cyc(1'b0, 1'b0, '0);
        irq_clr_v = 1'b0;
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b1, 1'b1, 16'hDEAD);
        irq_clr_v = 1'b1;
        cyc(1'b0, 1'b0, '0);
        irq_clr_v = 1'b0;
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, '0);

        // Underflow, read+write on empty, set-beats-clear
        cyc(1'b0, 1'b1, '0);
        irq_clr_v = 1'b1;
        cyc(1'b0, 1'b0, '0);
        irq_clr_v = 1'b0;
        cyc(1'b1, 1'b1, 16'h0055);
        cyc(1'b0, 1'b1, '0);
        irq_clr_v = 1'b1;
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, '0);
        irq_clr_v = 1'b0;

        // Steady state at count 8 with pointer wrap
        for (int i = 0; i < 8; i++)  cyc(1'b1, 1'b0, word_t'(16'h0200 + i));
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, word_t'(16'h0300 + i));
        for (int i = 0; i < 8; i++)  cyc(1'b0, 1'b1, '0);

        // Async reset mid-burst at count 7
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, word_t'(16'h0400 + i));
        cyc(1'b0, 1'b1, '0);
        cyc(1'b1, 1'b0, 16'h0407);
        bus0.wr_en = 1'b1;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs();
        #2 rst = 1'b0;
        cyc(1'b1, 1'b0, 16'h1234);
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, '0);

        // FWFT instance
        chk("fwft_dv_empty", 32'(bus1.data_valid), 32'h0);
        bus1.wr_en = 1'b1; bus1.data_in = 16'hA5A5;
        tick();
        bus1.wr_en = 1'b0;
        chk("fwft_data",  32'(bus1.data_out), 32'hA5A5);
        chk("fwft_dv",    32'(bus1.data_valid), 32'h1);
        chk("fwft_empty", 32'(bus1.empty), 32'h0);
        tick();
        chk("fwft_hold",  32'(bus1.data_out), 32'hA5A5);
        bus1.rd_en = 1'b1;
        tick();
        bus1.rd_en = 1'b0;
        chk("fwft_pop_empty", 32'(bus1.empty), 32'h1);
        chk("fwft_pop_dv",    32'(bus1.data_valid), 32'h0);
        chk("fwft_pop_count", 32'(bus1.count), 32'h0);
        bus1.wr_en = 1'b1; bus1.data_in = 16'h1111;
        tick();
        bus1.data_in = 16'h2222;
        tick();
        bus1.wr_en = 1'b0;
        chk("fwft_head0", 32'(bus1.data_out), 32'h1111);
        bus1.rd_en = 1'b1;
        tick();
        chk("fwft_head1", 32'(bus1.data_out), 32'h2222);
        chk("fwft_cnt1",  32'(bus1.count), 32'h1);
        tick();
        bus1.rd_en = 1'b0;
        chk("fwft_drained", 32'(bus1.empty), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
